// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, NOP encoding and fetch buffer entry type for the RISC-V front end.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [XLEN-1:0]       instr;
    logic                  misaligned;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry FIFO of fetch entries with push/pop/flush; flush may coincide with a push.
import riscv_pkg::*;
module fetch_skid_buffer #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);
  logic [1:0] cnt_q, cnt_d;
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic pop_ok;
  assign empty  = cnt_q == 2'd0;
  assign full   = cnt_q == 2'(DEPTH);
  assign pop_ok = pop && !empty;
  assign head   = e0_q;
  // e0 is always the head; e1 only holds data when two entries are buffered
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush) begin
      cnt_d = {1'b0, push};
      e0_d  = push ? din : e0_q;
    end else if (pop_ok && push) begin
      e0_d = full ? e1_q : din;
      e1_d = full ? din : e1_q;
    end else if (pop_ok) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end else if (push && !full) begin
      e0_d  = empty ? din : e0_q;
      e1_d  = empty ? e1_q : din;
      cnt_d = cnt_q + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, next-PC mux (redirect > +4 > hold) and fetch buffer feeding IF/ID.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects push one NOP fault entry and halt fetch until the next redirect.
module instruction_fetch_unit
  import riscv_pkg::fetch_entry_t;
  import riscv_pkg::RV_NOP;
#(
  parameter int                    XLEN         = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    BUF_DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [XLEN-1:0]       imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [XLEN-1:0]       if_instr,
  output logic                  if_misaligned
);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, tgt;
  fetch_entry_t din, head;
  logic push, pop, full, empty;
  assign pop = !empty && if_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q, halt_d, mis;
  assign mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign tgt = redirect_pc;
  assign push = mis || (!redirect_valid && !halt_q && (!full || pop));
  assign din = mis ? '{pc: redirect_pc, instr: RV_NOP, misaligned: 1'b1}
                   : '{pc: pc_q, instr: imem_instr, misaligned: 1'b0};
  always_comb halt_d = redirect_valid ? mis : halt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else        halt_q <= halt_d;
  end
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign push = !redirect_valid && (!full || pop);
  assign din = '{pc: pc_q, instr: imem_instr, misaligned: 1'b0};
`endif
  always_comb pc_d = redirect_valid ? tgt : (push ? pc_q + ADDR_WIDTH'(4) : pc_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_VECTOR;
    else        pc_q <= pc_d;
  end
  fetch_skid_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  assign imem_addr     = pc_q;
  assign if_valid      = !empty;
  assign if_pc         = head.pc;
  assign if_instr      = head.instr;
  assign if_misaligned = head.misaligned;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: random and directed stimulus against a queue-based fetch model with a handshake scoreboard.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr, redirect_pc = '0, if_pc, if_instr;
  logic        redirect_valid = 1'b0, if_valid, if_ready = 1'b0, if_misaligned;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] mpc = '0;
  logic        mhalt = 1'b0;
  int          n_tests = 0, n_fail = 0;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misaligned  (if_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign imem_instr = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    mpc = 32'h0;
    mhalt = 1'b0;
  endtask

  // Effect of one clock edge; the monitor has already retired any entry decode took this cycle.
  task automatic model_edge(input logic rv, input logic [31:0] rpc);
    if (!rst_n) model_clear();
    else if (rv) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      mhalt = rpc[1:0] != 2'b00;
      mpc = rpc;
      if (mhalt) exp_q.push_back('{rpc, 32'h0000_0013, 1'b1});
`else
      mpc = rpc & ~32'h3;
`endif
    end else if (!mhalt && exp_q.size() < 2) begin
      exp_q.push_back('{mpc, mem_word(mpc), 1'b0});
      mpc = mpc + 32'h4;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    if_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
    model_edge(rv, rpc);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_rst_valid", 32'(if_valid), 32'h0);
    check("async_rst_pc", if_pc, 32'h0);
    @(posedge clk);
    #1;
    model_edge(1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      check("imem_addr", imem_addr, mpc);
      if (if_valid && if_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
        check("if_misaligned", 32'(if_misaligned), 32'(e.mis));
      end
    end
  end

  initial begin : stim
    logic [31:0] rpc;
    #2;
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_mis", 32'(if_misaligned), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, '0);
    check("first_valid", 32'(if_valid), 32'h1);
    check("first_pc", if_pc, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    reset_pulse();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_pc", if_pc, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h100);
    check("redir_flush", 32'(if_valid), 32'h0);
    check("redir_addr", imem_addr, 32'h100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, '0);
    check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, '0);
    check("wrap_pc1", if_pc, 32'h0);
    step(1'b1, 1'b0, '0);
    reset_pulse();
    check("restart_addr", imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
`ifdef FETCH_MISALIGN_TRAP_EN
    step(1'b0, 1'b1, 32'h102);
    check("trap_pc", if_pc, 32'h102);
    check("trap_instr", if_instr, 32'h0000_0013);
    check("trap_mis", 32'(if_misaligned), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    check("trap_halt", 32'(if_valid), 32'h0);
    step(1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
`endif
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h3FFF);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rpc);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
